axi_rd_rr_arbiter: RTL
======================

// Module: axi_rd_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one AXI4 read master port (28b addr, 128b data, 1b ID) among NUM_REQ requesters.
//  Grants one burst at a time and sequences it: AR handshake, then R beats up to and including RLAST.
//  R beats are steered back to the granted requester; the master port feeds the clock-converter slave side.
//  Checks beat count against ARLEN and reports mismatches.
// PARAMETERS
//  NUM_REQ     4    number of requesters, 2..8
//  ADDR_W      28   AXI address width
//  DATA_W      128  AXI data width; ARSIZE fixed to log2(DATA_W/8)
// PORTS
//  m_axi_aclk     in   1                single clock for all logic
//  m_axi_aresetn  in   1                asynchronous active-low reset
//  req_valid      in   NUM_REQ          per-requester burst request
//  req_addr       in   NUM_REQ*ADDR_W   packed start addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_len        in   NUM_REQ*8        packed ARLEN (beats-1)
//  req_ready      out  NUM_REQ          one-hot; request accepted when valid&ready
//  rd_data        out  DATA_W           R data, shared bus
//  rd_resp        out  2                RRESP of current beat
//  rd_last        out  1                RLAST of current beat
//  rd_valid       out  NUM_REQ          one-hot beat valid to granted requester
//  rd_ready       in   NUM_REQ          per-requester beat ready
//  len_err        out  1                1-cycle pulse on beat-count mismatch
//  busy           out  1                high outside IDLE
//  m_axi_ar*      out  —                araddr/arlen/arvalid; arid=0, arsize=log2(DATA_W/8), arburst=INCR, others 0
//  m_axi_arready  in   1                AR handshake
//  m_axi_r*       in   —                rid/rdata/rresp/rlast/rvalid
//  m_axi_rready   out  1                R handshake
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; arvalid=0; req_ready=0; rd_valid=0; rready=0; len_err=0; busy=0; beat_cnt=0.
//  IDLE: if any req_valid, pick the first set bit at or after rr_ptr (wrap mod NUM_REQ).
//   - Assert req_ready[g] for exactly that cycle.
//   - Register addr/len into AR regs and g into grant.
//   - rr_ptr <= g+1 (wrap).
//   - Next state ADDR.
//  ADDR: arvalid=1 with stable araddr/arlen until arready. On handshake -> DATA, beat_cnt=0.
//  DATA: combinational pass-through, zero added latency:
//   - rd_valid[grant] = m_axi_rvalid.
//   - m_axi_rready = rd_ready[grant].
//   - rd_data, rd_resp, rd_last follow the R channel.
//   - Each R handshake increments beat_cnt (9b).
//   - Handshake with rlast=1 -> IDLE.
//  Length check: on the rlast handshake, if beat_cnt != len_q, pulse len_err.
//   - If beat_cnt == len_q and rlast=0, pulse len_err on that handshake and stay in DATA until rlast.
//  Grant latency: request seen in IDLE -> arvalid next cycle. Minimum 2 idle cycles between bursts (DATA->IDLE->ADDR).
//  Non-granted rd_valid bits are 0. rready=0 in IDLE and ADDR.
//  req_valid deassert after acceptance has no effect. An unaccepted request may be withdrawn.
//  Requests arriving during ADDR/DATA wait for the next IDLE; no reordering.
//  Only one outstanding burst; rid is ignored.
//  Reset mid-burst: all outputs return to reset values immediately; the in-flight burst is abandoned.
//  4 KB crossing is not checked; requesters guarantee legality.
// TESTING
//  1. Single req0: addr 0x0001000, len 3, arready after 2 cycles.
//     -> araddr=0x0001000, arlen=3, 4 beats to rd_valid[0], busy low after RLAST.
//  2. All 4 requesting continuously, len 0.
//     -> grant order 0,1,2,3,0; rr_ptr wraps.
//  3. req_valid=4'b1010 with rr_ptr=2.
//     -> grant 3, then 1.
//  4. rd_ready[g] toggled every other cycle during a 16-beat burst.
//     -> rready mirrors it; no beats lost; data order preserved.
//  5. Slave returns rlast on beat 2 of len 3.
//     -> len_err pulses once; IDLE next.
//  6. Assert aresetn low during DATA beat 5.
//     -> all outputs at reset values same cycle; next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters.
// One burst at a time: pick requester, issue AR, then steer R beats back to it.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn   clock, async active-low reset
//   req_valid/addr/len          per-requester burst requests (packed)
//   req_ready                   one-hot accept pulse in IDLE
//   rd_data/resp/last           R channel pass-through (shared bus)
//   rd_valid/rd_ready           per-requester beat handshake
//   len_err                     1-cycle pulse when beat count disagrees with ARLEN
//   busy                        high outside IDLE
//   m_axi_ar*/m_axi_r*          AXI4 read master port
module axi_rd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [1:0]                rd_resp,
    output logic                      rd_last,
    output logic [NUM_REQ-1:0]        rd_valid,
    input  logic [NUM_REQ-1:0]        rd_ready,
    output logic                      len_err,
    output logic                      busy,
    output logic [0:0]                m_axi_arid,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [0:0]                m_axi_rid,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [8:0]          beat_cnt;

    logic                found;
    logic [PW-1:0]       pick;
    logic [PW:0]         idx_w;
    logic [PW-1:0]       idx;
    logic [ADDR_W-1:0]   pick_addr;
    logic [7:0]          pick_len;
    logic                take;
    logic                r_hs;
    logic                rid_unused;

    // Only one burst is ever outstanding, so the ID carries no information.
    assign rid_unused = m_axi_rid[0];

    // Search from rr_ptr upward, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx_w = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_w = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx_w >= (PW+1)'(NUM_REQ)) begin
                idx_w = idx_w - (PW+1)'(NUM_REQ);
            end
            idx = idx_w[PW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PW'(i)) begin
                pick_addr = req_addr[i*ADDR_W +: ADDR_W];
                pick_len  = req_len[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        take         = 1'b0;
        req_ready    = '0;
        rd_valid     = '0;
        m_axi_rready = 1'b0;
        r_hs         = 1'b0;
        len_err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so the accept pulse is dead while held in reset.
                if (found && m_axi_aresetn) begin
                    take            = 1'b1;
                    req_ready[pick] = 1'b1;
                    state_d         = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                rd_valid[grant_q] = m_axi_rvalid;
                m_axi_rready      = rd_ready[grant_q];
                r_hs              = m_axi_rvalid && rd_ready[grant_q];
                if (r_hs) begin
                    if (m_axi_rlast) begin
                        state_d = IDLE;
                        len_err = (beat_cnt != {1'b0, len_q});
                    end else begin
                        // Expected last beat arrived without RLAST.
                        len_err = (beat_cnt == {1'b0, len_q});
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q  <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q  <= pick_addr;
                len_q   <= pick_len;
                grant_q <= pick;
                if (pick == PW'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= pick + PW'(1);
                end
            end
            if (state_q == ADDR && m_axi_arready) begin
                beat_cnt <= '0;
            end else if (r_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arid    = 1'b0;
    assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    assign rd_data = m_axi_rdata;
    assign rd_resp = m_axi_rresp;
    assign rd_last = m_axi_rlast;

endmodule
